ram_sdp_init: RTL
=================

Name: ram_sdp_init

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, single clock.
- Adds per-byte write enables, configurable read latency and read/write collision mode.
- Built-in clear sequencer zeroes the array after reset or on request.
- Storage successor to the basic 16x8 single-port RAM; serves as a general scratchpad and buffer memory across the design.

Parameters:
DATA_W, 16, data width in bits; must be a multiple of 8
ADDR_W, 4, address width
DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; 1 or 2 only
WRITE_MODE, 0, same-address collision: 0 = read-first (old data), 1 = write-first (new data)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  request a full-array clear; sampled only in READY
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data
rd_valid  out  1  one-cycle pulse; rd_data is valid in this cycle
busy  out  1  clear sequencer active; requests are not served
drop  out  1  one-cycle pulse; a request was rejected

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n is asynchronous and active-low.
- Reset values:
  - State = CLEAR, clear pointer = 0.
  - busy = 1, rd_data = 0, rd_valid = 0, drop = 0.
  - Read pipeline registers = 0.
  - Array contents are not reset directly; the sequencer clears them.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each rising edge writes 0 to mem[ptr] and increments ptr.
  - On the edge that writes DEPTH-1: state -> READY, busy <= 0, ptr <= 0.
  - busy is therefore high during reset and for exactly DEPTH edges after release.
  - clr is ignored in CLEAR; it does not restart the sequence.
- READY, clr = 1: state -> CLEAR on that edge. Any rd_en/wr_en sampled on the same edge is still served.
- Rejected requests:
  - wr_en or rd_en sampled while busy = 1 is not executed.
  - drop = 1 on the following cycle; rd_valid stays 0.
  - Simultaneous rejected read and write produce a single drop pulse.
- Write (READY):
  - On the edge, for each i with wr_be[i] = 1: mem[wr_addr][8i+7:8i] <= wr_data[8i+7:8i].
  - Lanes with wr_be[i] = 0 keep their value.
  - wr_be = 0 is a legal no-op; drop stays 0.
- Read (READY):
  - rd_en sampled on edge N.
  - rd_data and rd_valid update after edge N+RD_LAT-1: the next cycle for RD_LAT = 1, one cycle later for RD_LAT = 2.
  - Fully pipelined; one read per cycle sustained.
  - rd_data holds its last value when rd_valid = 0.
- Collision (same edge, wr_addr == rd_addr, both in range):
  - WRITE_MODE = 0: returns pre-write word.
  - WRITE_MODE = 1: returns merged word; enabled lanes carry new data, disabled lanes carry old data.
- Out-of-range address (>= DEPTH):
  - Write is ignored; drop pulses.
  - Read returns rd_data = 0 with rd_valid = 1 at normal latency; drop pulses.
- Clear during in-flight reads: reads already in the RD_LAT = 2 pipeline complete normally with rd_valid.
- Reset mid-operation:
  - The pipeline is flushed; rd_valid = 0 immediately (asynchronous).
  - The clear restarts from address 0 after release.
- Parameter checks: illegal RD_LAT, DATA_W not a multiple of 8, or DEPTH > 2**ADDR_W is an elaboration error.

Test Plan:
- Reset release with default parameters -> busy high for exactly 16 rising edges, then 0. Reads of addresses 0..15 all return 0x0000 with one rd_valid pulse each, 1 cycle after rd_en.
- Write 0xA5C3 to addr 3 with be = 2'b11, then 0x00FF to addr 3 with be = 2'b01; read addr 3 -> rd_data = 0xA5FF.
- Preload mem[5] = 0x1111. Same edge: write 0x2222 be = 2'b10 and read addr 5 -> 0x1111 with WRITE_MODE = 0; 0x2211 with WRITE_MODE = 1.
- After writing addr 3, pulse clr:
  - busy is high for 16 cycles.
  - wr_en to addr 7 during busy -> drop pulse next cycle, no write.
  - Afterwards addr 3 and addr 7 read 0x0000.
- RD_LAT = 2: back-to-back reads of addr 1 (0x0101) and addr 2 (0x0202) -> rd_valid high on two consecutive cycles starting 2 cycles after the first rd_en, data 0x0101 then 0x0202.
- DEPTH = 12: write 0xBEEF to addr 13 -> drop pulse. Read addr 13 -> rd_valid = 1, rd_data = 0, drop pulse. Assert rst_n = 0 at clear pointer 6 -> after release, busy stays high for a full 12 edges.

Source files
------------

// File: rtl/ram_sdp_init.sv
// -----------------------------------------------------------------------------
// ram_sdp_init
//
// Simple-dual-port synchronous RAM (one write port, one read port, one clock)
// with per-byte write enables, a configurable read latency (1 or 2 cycles),
// a selectable same-address read/write collision behaviour and a built-in
// clear sequencer. The sequencer zeroes the whole array after every reset and
// on request (clr), one word per clock. While it runs, busy is high and all
// requests are rejected.
//
// Parameters
//   DATA_W     data width in bits, multiple of 8
//   ADDR_W     address width
//   DEPTH      number of words, 1 .. 2**ADDR_W
//   RD_LAT     read latency in cycles, 1 or 2
//   WRITE_MODE collision result: 0 = old word, 1 = merged new word
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clr       full-array clear request, honoured only when not busy
//   wr_en     write request
//   wr_addr   write address
//   wr_be     byte enables, bit i covers wr_data[8i+7:8i]
//   wr_data   write data
//   rd_en     read request
//   rd_addr   read address
//   rd_data   read data, holds its value while rd_valid is low
//   rd_valid  one-cycle pulse marking valid rd_data
//   busy      clear sequencer active
//   drop      one-cycle pulse: a request was rejected (busy or out of range)
// -----------------------------------------------------------------------------
module ram_sdp_init #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LAT     = 1,
  parameter int WRITE_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  drop
);

  localparam int NB = DATA_W / 8;
  // DEPTH widened by one bit so that DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  // Elaboration-time parameter legality checks.
  generate
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
      $error("ram_sdp_init: RD_LAT must be 1 or 2");
    end
    if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
      $error("ram_sdp_init: DATA_W must be a non-zero multiple of 8");
    end
    if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_depth
      $error("ram_sdp_init: DEPTH must be in 1 .. 2**ADDR_W");
    end
    if ((WRITE_MODE != 0) && (WRITE_MODE != 1)) begin : g_bad_write_mode
      $error("ram_sdp_init: WRITE_MODE must be 0 or 1");
    end
  endgenerate

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Byte-lane merge: enabled lanes take the new word, others keep the old one.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              busy_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              drop_r;

  logic              ready_s;
  logic              wr_in_range_s;
  logic              rd_in_range_s;
  logic              wr_do_s;
  logic              rd_do_s;
  logic              drop_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              out_valid_s;
  logic [DATA_W-1:0] out_data_s;

  // Request qualification, drop detection and read word selection.
  always_comb begin
    ready_s       = (state_r == ST_READY);
    wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
    rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
    wr_do_s       = ready_s && wr_en && wr_in_range_s;
    // Out-of-range reads are still answered (with zero) at normal latency.
    rd_do_s       = ready_s && rd_en;
    drop_s        = (!ready_s && (wr_en || rd_en)) ||
                    (ready_s && wr_en && !wr_in_range_s) ||
                    (ready_s && rd_en && !rd_in_range_s);
    rd_word_s     = {DATA_W{1'b0}};
    if (rd_in_range_s) begin
      if ((WRITE_MODE == 1) && wr_do_s && (wr_addr == rd_addr)) begin
        // Write-first: forward the word as it will look after this edge.
        rd_word_s = merge_bytes(mem_r[rd_addr], wr_data, wr_be);
      end else begin
        rd_word_s = mem_r[rd_addr];
      end
    end else begin
      rd_word_s = {DATA_W{1'b0}};
    end
  end

  // Clear sequencer FSM: walks ptr over the array, then serves requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      ptr_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (ptr_r == LAST_PTR) begin
            state_r <= ST_READY;
            ptr_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
          end else begin
            ptr_r   <= ptr_r + ADDR_W'(1);
          end
        end
        ST_READY: begin
          if (clr) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_READY;
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          ptr_r   <= {ADDR_W{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: sequencer clears take priority, otherwise byte-masked writes.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[ptr_r] <= {DATA_W{1'b0}};
    end else if (wr_do_s) begin
      mem_r[wr_addr] <= merge_bytes(mem_r[wr_addr], wr_data, wr_be);
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              pipe_valid_r;
      logic [DATA_W-1:0] pipe_data_r;

      // Extra read stage; it keeps draining even after a clear starts.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_valid_r <= 1'b0;
          pipe_data_r  <= {DATA_W{1'b0}};
        end else begin
          pipe_valid_r <= rd_do_s;
          if (rd_do_s) begin
            pipe_data_r <= rd_word_s;
          end else begin
            pipe_data_r <= pipe_data_r;
          end
        end
      end

      // Output stage is fed from the extra read stage.
      always_comb begin
        out_valid_s = pipe_valid_r;
        out_data_s  = pipe_data_r;
      end
    end else begin : g_lat1
      // Output stage is fed straight from the array read.
      always_comb begin
        out_valid_s = rd_do_s;
        out_data_s  = rd_word_s;
      end
    end
  endgenerate

  // Registered outputs; rd_data only moves when a valid word arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
      drop_r     <= 1'b0;
    end else begin
      rd_valid_r <= out_valid_s;
      drop_r     <= drop_s;
      if (out_valid_s) begin
        rd_data_r <= out_data_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign drop     = drop_r;

  ram_sdp_init_chk #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .is_clear (state_r == ST_CLEAR),
    .ptr      (ptr_r),
    .busy     (busy_r)
  );

endmodule

// -----------------------------------------------------------------------------
// ram_sdp_init_chk
//
// Internal consistency properties of the clear sequencer.
//   is_clear  sequencer state is CLEAR
//   ptr       clear pointer
//   busy      registered busy flag
// -----------------------------------------------------------------------------
module ram_sdp_init_chk #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_clear,
  input  logic [ADDR_W-1:0] ptr,
  input  logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // busy must mirror the sequencer state at all times.
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n) busy == is_clear);

  // The clear pointer never addresses past the end of the array.
  a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n) ({1'b0, ptr} < DEPTH_L));

  // The pointer is parked at zero whenever the array is being served.
  a_ptr_idle: assert property (@(posedge clk) disable iff (!rst_n) (!is_clear) |-> (ptr == {ADDR_W{1'b0}}));

endmodule
